// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-side types: RAM handshake state, word type and the
// arbiter grant state.
package cpu_types_pkg;
  localparam int CPU_WORD_W = 32;
  localparam int ARB_CNT_W  = 4;

  typedef logic [CPU_WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } arbstate_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-pair and RAM-port signals around the memory arbiter.
// master = arbiter side, slave = caches plus RAM model.
interface mem_arbiter_if import cpu_types_pkg::*; #(parameter int WORD_W = 32) ();
  logic              iREN;
  logic [WORD_W-1:0] iaddr;
  logic              iwait;
  logic [WORD_W-1:0] iload;
  logic              dREN;
  logic              dWEN;
  logic [WORD_W-1:0] daddr;
  logic [WORD_W-1:0] dstore;
  logic              dwait;
  logic [WORD_W-1:0] dload;
  logic              ramREN;
  logic              ramWEN;
  logic [WORD_W-1:0] ramaddr;
  logic [WORD_W-1:0] ramstore;
  logic [WORD_W-1:0] ramload;
  ramstate_t         ramstate;

  modport master (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
  modport slave (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_arb_pick.sv
// Arbitration choice: dcache wins unless it has used up its quota while
// the icache is waiting.
module mem_arb_pick import cpu_types_pkg::*; #(
  parameter int DPRIO_MAX = 4
) (
  input  logic                 iren,
  input  logic                 dreq,
  input  logic [ARB_CNT_W-1:0] cnt,
  output arbstate_t            pick
);
  always_comb begin
    if (dreq && ((cnt < ARB_CNT_W'(DPRIO_MAX)) || !iren)) pick = DGNT;
    else if (iren)                                       pick = IGNT;
    else                                                 pick = IDLE;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Shares one RAM port between icache fills and dcache reads/writes.
// Optional ARB_PERF_CNT_EN adds completion and stall counters.
module mem_arbiter import cpu_types_pkg::*; #(
  parameter int WORD_W    = 32,
  parameter int DPRIO_MAX = 4
) (
  input  logic CLK,
  input  logic nRST,
  mem_arbiter_if.master bus
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0] icnt,
  output logic [31:0] dcnt,
  output logic [31:0] stallcnt
`endif
);
  arbstate_t            state, state_nxt, pick_cur, pick_upd;
  logic [ARB_CNT_W-1:0] cnt, cnt_nxt;
  logic                 dreq, done, iwait_c, dwait_c;
  logic                 ren_c, wen_c;
  logic [WORD_W-1:0]    addr_c, store_c;

  assign dreq = bus.dREN | bus.dWEN;
  assign done = (bus.ramstate == ACCESS) && (state != IDLE);

  // Starvation count as it will be after this cycle; completion arbitration uses it.
  always_comb begin
    cnt_nxt = cnt;
    if (done && state == IGNT) cnt_nxt = '0;
    else if (done && state == DGNT) begin
      if (!bus.iREN)                          cnt_nxt = '0;
      else if (cnt >= ARB_CNT_W'(DPRIO_MAX))  cnt_nxt = ARB_CNT_W'(DPRIO_MAX);
      else                                    cnt_nxt = cnt + 1'b1;
    end
  end

  mem_arb_pick #(.DPRIO_MAX(DPRIO_MAX)) u_pick_cur (
    .iren(bus.iREN), .dreq(dreq), .cnt(cnt),     .pick(pick_cur));
  mem_arb_pick #(.DPRIO_MAX(DPRIO_MAX)) u_pick_upd (
    .iren(bus.iREN), .dreq(dreq), .cnt(cnt_nxt), .pick(pick_upd));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = pick_cur;
      IGNT:    if (done) state_nxt = pick_upd; else if (!bus.iREN) state_nxt = pick_cur;
      DGNT:    if (done) state_nxt = pick_upd; else if (!dreq)     state_nxt = pick_cur;
      default: state_nxt = IDLE;
    endcase
  end

  // RAM controls follow the granted requester combinationally, so an abort
  // drops the enables in the same cycle and reset clears them asynchronously.
  always_comb begin
    ren_c   = 1'b0;
    wen_c   = 1'b0;
    addr_c  = '0;
    store_c = '0;
    iwait_c = 1'b1;
    dwait_c = 1'b1;
    case (state)
      IGNT: begin
        ren_c   = bus.iREN;
        addr_c  = bus.iaddr;
        iwait_c = !(bus.ramstate == ACCESS);
      end
      DGNT: begin
        wen_c   = bus.dWEN;
        ren_c   = bus.dREN & !bus.dWEN;
        addr_c  = bus.daddr;
        store_c = bus.dstore;
        dwait_c = !(bus.ramstate == ACCESS);
      end
      default: ;
    endcase
  end

  assign bus.ramREN   = ren_c;
  assign bus.ramWEN   = wen_c;
  assign bus.ramaddr  = addr_c;
  assign bus.ramstore = store_c;
  assign bus.iwait    = iwait_c;
  assign bus.dwait    = dwait_c;
  assign bus.iload    = bus.ramload;
  assign bus.dload    = bus.ramload;

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      icnt     <= '0;
      dcnt     <= '0;
      stallcnt <= '0;
    end else begin
      if (done && state == IGNT) icnt <= icnt + 32'd1;
      if (done && state == DGNT) dcnt <= dcnt + 32'd1;
      if ((bus.iREN && iwait_c) || (dreq && dwait_c)) stallcnt <= stallcnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table for single-cycle behaviour,
// hand sequences for starvation bound and mid-transaction reset.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.WORD_W(32)) bus ();
`ifdef ARB_PERF_CNT_EN
  logic [31:0] icnt, dcnt, stallcnt;
`endif

  mem_arbiter #(.WORD_W(32), .DPRIO_MAX(4)) dut (
    .CLK(clk), .nRST(rst_n), .bus(bus)
`ifdef ARB_PERF_CNT_EN
    , .icnt(icnt), .dcnt(dcnt), .stallcnt(stallcnt)
`endif
  );

  typedef struct {
    logic        iren, dren, dwen;
    logic [31:0] iaddr, daddr, dstore;
    ramstate_t   rs;
    logic        e_ren, e_wen;
    logic [31:0] e_addr, e_store;
    logic        e_iw, e_dw;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;
  vec_t vt[22];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(logic iren, logic dren, logic dwen, logic [31:0] iaddr,
                              logic [31:0] daddr, logic [31:0] dstore, ramstate_t rs,
                              logic ren, logic wen, logic [31:0] addr, logic [31:0] store,
                              logic iw, logic dw);
    vec_t v;
    v.iren = iren; v.dren = dren; v.dwen = dwen;
    v.iaddr = iaddr; v.daddr = daddr; v.dstore = dstore; v.rs = rs;
    v.e_ren = ren; v.e_wen = wen; v.e_addr = addr; v.e_store = store;
    v.e_iw = iw; v.e_dw = dw;
    return v;
  endfunction

  task automatic drive(logic iren, logic dren, logic dwen, logic [31:0] iaddr,
                       logic [31:0] daddr, logic [31:0] dstore, ramstate_t rs);
    bus.iREN = iren; bus.dREN = dren; bus.dWEN = dwen;
    bus.iaddr = iaddr; bus.daddr = daddr; bus.dstore = dstore; bus.ramstate = rs;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, FREE);
    bus.ramload = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int pat[10];
    // idle, then icache read completing on first grant cycle
    vt[0]  = mk(0,0,0, 32'h0, 32'h0, 32'h0, FREE,    0,0,32'h0, 32'h0, 1,1);
    vt[1]  = mk(1,0,0, 32'h40,32'h0, 32'h0, FREE,    0,0,32'h0, 32'h0, 1,1);
    vt[2]  = mk(1,0,0, 32'h40,32'h0, 32'h0, ACCESS,  1,0,32'h40,32'h0, 0,1);
    vt[3]  = mk(0,0,0, 32'h40,32'h0, 32'h0, FREE,    0,0,32'h40,32'h0, 1,1);
    vt[4]  = mk(0,0,0, 32'h0, 32'h0, 32'h0, FREE,    0,0,32'h0, 32'h0, 1,1);
    // dcache write with read also set: write wins
    vt[5]  = mk(0,1,1, 32'h0, 32'h80,32'hDEADBEEF, FREE,   0,0,32'h0, 32'h0,      1,1);
    vt[6]  = mk(0,1,1, 32'h0, 32'h80,32'hDEADBEEF, ACCESS, 0,1,32'h80,32'hDEADBEEF,1,0);
    vt[7]  = mk(0,0,0, 32'h0, 32'h80,32'hDEADBEEF, FREE,   0,0,32'h80,32'hDEADBEEF,1,1);
    // simultaneous requests, BUSY twice: DGNT first, then IGNT without idle gap
    vt[8]  = mk(1,1,0, 32'h44,32'h84,32'h0, FREE,    0,0,32'h0, 32'h0, 1,1);
    vt[9]  = mk(1,1,0, 32'h44,32'h84,32'h0, BUSY,    1,0,32'h84,32'h0, 1,1);
    vt[10] = mk(1,1,0, 32'h44,32'h84,32'h0, BUSY,    1,0,32'h84,32'h0, 1,1);
    vt[11] = mk(1,0,0, 32'h44,32'h84,32'h0, ACCESS,  0,0,32'h84,32'h0, 1,0);
    vt[12] = mk(1,0,0, 32'h44,32'h84,32'h0, BUSY,    1,0,32'h44,32'h0, 1,1);
    vt[13] = mk(1,0,0, 32'h44,32'h84,32'h0, BUSY,    1,0,32'h44,32'h0, 1,1);
    vt[14] = mk(0,0,0, 32'h44,32'h84,32'h0, ACCESS,  0,0,32'h44,32'h0, 0,1);
    // dcache abort during ERROR/BUSY hold, then icache picked up
    vt[15] = mk(0,1,0, 32'h0, 32'h88,32'h0, FREE,    0,0,32'h0, 32'h0, 1,1);
    vt[16] = mk(0,1,0, 32'h0, 32'h88,32'h0, ERROR,   1,0,32'h88,32'h0, 1,1);
    vt[17] = mk(1,0,0, 32'h48,32'h88,32'h0, BUSY,    0,0,32'h88,32'h0, 1,1);
    vt[18] = mk(1,0,0, 32'h48,32'h88,32'h0, FREE,    1,0,32'h48,32'h0, 1,1);
    vt[19] = mk(1,0,0, 32'h48,32'h88,32'h0, ACCESS,  1,0,32'h48,32'h0, 0,1);
    vt[20] = mk(0,0,0, 32'h0, 32'h0, 32'h0, FREE,    0,0,32'h0, 32'h0, 1,1);
    vt[21] = mk(0,0,0, 32'h0, 32'h0, 32'h0, FREE,    0,0,32'h0, 32'h0, 1,1);
    pat = '{1,1,1,1,0,1,1,1,1,0};

    do_reset();
    #2;
    chk("reset ramREN", 32'(bus.ramREN), 0);
    chk("reset ramWEN", 32'(bus.ramWEN), 0);
    chk("reset ramaddr", bus.ramaddr, 0);
    chk("reset ramstore", bus.ramstore, 0);
    chk("reset iwait", 32'(bus.iwait), 1);
    chk("reset dwait", 32'(bus.dwait), 1);

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      drive(vt[i].iren, vt[i].dren, vt[i].dwen, vt[i].iaddr, vt[i].daddr, vt[i].dstore, vt[i].rs);
      bus.ramload = 32'hC0DE0000 + 32'(i);
      #2;
      chk($sformatf("v%0d ramREN", i),   32'(bus.ramREN), 32'(vt[i].e_ren));
      chk($sformatf("v%0d ramWEN", i),   32'(bus.ramWEN), 32'(vt[i].e_wen));
      chk($sformatf("v%0d ramaddr", i),  bus.ramaddr,     vt[i].e_addr);
      chk($sformatf("v%0d ramstore", i), bus.ramstore,    vt[i].e_store);
      chk($sformatf("v%0d iwait", i),    32'(bus.iwait),  32'(vt[i].e_iw));
      chk($sformatf("v%0d dwait", i),    32'(bus.dwait),  32'(vt[i].e_dw));
      chk($sformatf("v%0d iload", i),    bus.iload,       32'hC0DE0000 + 32'(i));
      chk($sformatf("v%0d dload", i),    bus.dload,       32'hC0DE0000 + 32'(i));
    end

    // Starvation bound: both requesting, zero-wait RAM -> 4 D, 1 I, repeat.
    do_reset();
    @(negedge clk);
    drive(1, 1, 0, 32'h4C, 32'h8C, 0, ACCESS);
    #2;
    chk("starve idle ramREN", 32'(bus.ramREN), 0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #2;
      chk($sformatf("starve c%0d dwait", k+1), 32'(bus.dwait), 32'(pat[k] == 0));
      chk($sformatf("starve c%0d iwait", k+1), 32'(bus.iwait), 32'(pat[k] == 1));
      chk($sformatf("starve c%0d ramaddr", k+1), bus.ramaddr, (pat[k] == 1) ? 32'h8C : 32'h4C);
    end

    // Reset asserted while a dcache read is stalled on BUSY.
    do_reset();
    @(negedge clk);
    drive(0, 1, 0, 0, 32'h90, 0, FREE);
    @(negedge clk);
    bus.ramstate = BUSY;
    #2;
    chk("rst pre ramREN", 32'(bus.ramREN), 1);
    chk("rst pre ramaddr", bus.ramaddr, 32'h90);
    #1 rst_n = 1'b0;
    #1;
    chk("rst async ramREN", 32'(bus.ramREN), 0);
    chk("rst async ramWEN", 32'(bus.ramWEN), 0);
    chk("rst async iwait", 32'(bus.iwait), 1);
    chk("rst async dwait", 32'(bus.dwait), 1);
    chk("rst async ramaddr", bus.ramaddr, 0);
`ifdef ARB_PERF_CNT_EN
    chk("rst icnt", icnt, 0);
    chk("rst dcnt", dcnt, 0);
    chk("rst stallcnt", stallcnt, 0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.ramstate = FREE;
    #2;
    chk("rst restart idle ramREN", 32'(bus.ramREN), 0);
    @(negedge clk);
    #2;
    chk("rst restart ramREN", 32'(bus.ramREN), 1);
    chk("rst restart ramaddr", bus.ramaddr, 32'h90);
    chk("rst restart dwait", 32'(bus.dwait), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
